// File: rtl/hockey_param.sv
// Two-player grid hockey: serve, puck travel with wall bounce, hit window, scoring, win detect.
// Latency: button edges act on the next clock; puck steps every P clocks; backpressure: none.
module hockey_param #(
   parameter int unsigned GRID      = 5,
   parameter int unsigned WIN_SCORE = 3,
   parameter int unsigned STEP_CYC  = 4,
   parameter int unsigned RESP_CYC  = 8,
   parameter int unsigned GOAL_CYC  = 6,
   parameter int unsigned PW        = (GRID > 2) ? $clog2(GRID) : 1,
   parameter int unsigned SW        = $clog2(WIN_SCORE + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            BTNA,
   input  logic            BTNB,
   input  logic [1:0]      DIRA,
   input  logic [1:0]      DIRB,
   input  logic [PW-1:0]   YA,
   input  logic [PW-1:0]   YB,
   output logic            LEDA,
   output logic            LEDB,
   output logic [GRID-1:0] LEDX,
   output logic [PW-1:0]   X,
   output logic [PW-1:0]   Y,
   output logic [SW-1:0]   SCOREA,
   output logic [SW-1:0]   SCOREB,
   output logic [1:0]      WINNER
);

   typedef enum logic [2:0] {
      S_IDLE, S_SERVE, S_MOVE, S_RESP, S_GOAL, S_OVER
   } state_t;

   localparam logic [PW-1:0]   XMAX    = PW'(GRID - 1);
   localparam logic [SW-1:0]   WIN     = SW'(WIN_SCORE);
   localparam logic [7:0]      P_INIT  = 8'(STEP_CYC);
   localparam logic [15:0]     RESP_LST = 16'(RESP_CYC - 1);
   localparam logic [15:0]     GOAL_LST = 16'(GOAL_CYC - 1);
   localparam logic [GRID-1:0] ONE_HOT0 = GRID'(1);

   state_t        state_q, state_d;
   logic [PW-1:0] x_q, x_d, y_q, y_d;
   logic [1:0]    vdir_q, vdir_d;     // 00 straight, 01 Y up, 10 Y down
   logic          xdir_q, xdir_d;     // 1: travelling toward B
   logic          srv_q, srv_d;       // 0: A, 1: B
   logic          scorer_q, scorer_d;
   logic [7:0]    p_q, p_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [SW-1:0] sa_q, sa_d, sb_q, sb_d;
   logic [1:0]    win_q, win_d;
   logic          btna_q, btnb_q;

   logic          edge_a, edge_b, srv_edge, rcv_edge;
   logic [PW-1:0] srv_y, rcv_y, x_step;
   logic [1:0]    srv_dir, rcv_dir;

   function automatic logic [1:0] norm_dir(input logic [1:0] d);
      return (d == 2'b11) ? 2'b00 : d;
   endfunction

   assign edge_a   = BTNA & ~btna_q;
   assign edge_b   = BTNB & ~btnb_q;
   assign srv_edge = srv_q ? edge_b : edge_a;
   assign srv_y    = srv_q ? YB : YA;
   assign srv_dir  = srv_q ? DIRB : DIRA;
   assign rcv_edge = xdir_q ? edge_b : edge_a;
   assign rcv_y    = xdir_q ? YB : YA;
   assign rcv_dir  = xdir_q ? DIRB : DIRA;
   assign x_step   = xdir_q ? (x_q + 1'b1) : (x_q - 1'b1);

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      vdir_d   = vdir_q;
      xdir_d   = xdir_q;
      srv_d    = srv_q;
      scorer_d = scorer_q;
      p_d      = p_q;
      cnt_d    = cnt_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      win_d    = win_q;
      case (state_q)
         S_IDLE: begin
            if (edge_a) begin
               srv_d   = 1'b0;
               state_d = S_SERVE;
            end else if (edge_b) begin
               srv_d   = 1'b1;
               state_d = S_SERVE;
            end
         end
         S_SERVE: begin
            if (srv_edge && (32'(srv_y) < GRID)) begin
               x_d     = srv_q ? XMAX : '0;
               y_d     = srv_y;
               vdir_d  = norm_dir(srv_dir);
               xdir_d  = ~srv_q;
               p_d     = P_INIT;
               cnt_d   = '0;
               state_d = S_MOVE;
            end
         end
         S_MOVE: begin
            if (cnt_q == ({8'd0, p_q} - 16'd1)) begin
               cnt_d = '0;
               x_d   = x_step;
               // A wall hit reflects the puck within the same step
               case (vdir_q)
                  2'b01: begin
                     if (y_q == XMAX) begin
                        y_d    = y_q - 1'b1;
                        vdir_d = 2'b10;
                     end else begin
                        y_d = y_q + 1'b1;
                     end
                  end
                  2'b10: begin
                     if (y_q == '0) begin
                        y_d    = y_q + 1'b1;
                        vdir_d = 2'b01;
                     end else begin
                        y_d = y_q - 1'b1;
                     end
                  end
                  default: y_d = y_q;
               endcase
               if (x_step == (xdir_q ? XMAX : '0)) state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RESP: begin
            if (rcv_edge && (rcv_y == y_q)) begin
               xdir_d  = ~xdir_q;
               vdir_d  = norm_dir(rcv_dir);
               p_d     = (p_q > 8'd1) ? (p_q - 8'd1) : 8'd1;
               cnt_d   = '0;
               state_d = S_MOVE;
            end else if (rcv_edge || (cnt_q == RESP_LST)) begin
               scorer_d = ~xdir_q;
               if (xdir_q) begin
                  if (sa_q < WIN) sa_d = sa_q + 1'b1;
               end else begin
                  if (sb_q < WIN) sb_d = sb_q + 1'b1;
               end
               cnt_d   = '0;
               state_d = S_GOAL;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_GOAL: begin
            if (cnt_q == GOAL_LST) begin
               cnt_d = '0;
               if ((scorer_q ? sb_q : sa_q) == WIN) begin
                  win_d   = scorer_q ? 2'b10 : 2'b01;
                  state_d = S_OVER;
               end else begin
                  srv_d   = ~scorer_q;
                  state_d = S_SERVE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_OVER:  state_d = S_OVER;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         vdir_q   <= '0;
         xdir_q   <= 1'b0;
         srv_q    <= 1'b0;
         scorer_q <= 1'b0;
         p_q      <= P_INIT;
         cnt_q    <= '0;
         sa_q     <= '0;
         sb_q     <= '0;
         win_q    <= '0;
         btna_q   <= 1'b0;
         btnb_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vdir_q   <= vdir_d;
         xdir_q   <= xdir_d;
         srv_q    <= srv_d;
         scorer_q <= scorer_d;
         p_q      <= p_d;
         cnt_q    <= cnt_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         win_q    <= win_d;
         btna_q   <= BTNA;
         btnb_q   <= BTNB;
      end
   end

   always_comb begin
      LEDA = ((state_q == S_SERVE) && !srv_q) || ((state_q == S_RESP) && !xdir_q);
      LEDB = ((state_q == S_SERVE) &&  srv_q) || ((state_q == S_RESP) &&  xdir_q);
      LEDX = '0;
      if ((state_q == S_MOVE) || (state_q == S_RESP)) LEDX = ONE_HOT0 << x_q;
      else if (state_q == S_GOAL)                     LEDX = '1;
   end

   assign X      = x_q;
   assign Y      = y_q;
   assign SCOREA = sa_q;
   assign SCOREB = sb_q;
   assign WINNER = win_q;

endmodule
